jtkicker_colmix_n: RTL and testbench



---
 rtl/jtkicker_colmix_n.sv | 113 +++++++++++
 tb/tb_jtkicker_colmix_n.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtkicker_colmix_n.sv
// Colour mixer for N tile/sprite layers: priority with transparency, PROM palette
// lookup and blanking, with a 3-tick pipeline on pxl_cen.
module jtkicker_colmix_n #(
    parameter int LAYERS = 2,
    parameter int PXLW   = 4,
    parameter int PALW   = 3,
    parameter int AW     = PALW + (LAYERS <= 2 ? 1 : 2) + PXLW,
    parameter int COLW   = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     pxl_cen,
    input  logic [PALW-1:0]          pal_sel,
    input  logic                     prio_swap,
    input  logic [LAYERS-1:0]        layer_en,
    input  logic [LAYERS*PXLW-1:0]   layer_pxl,
    input  logic                     LHBL,
    input  logic                     LVBL,
    input  logic [AW-1:0]            prog_addr,
    input  logic [COLW-1:0]          prog_data,
    input  logic [2:0]               prog_en,
    output logic [COLW-1:0]          red,
    output logic [COLW-1:0]          green,
    output logic [COLW-1:0]          blue,
    output logic                     LHBL_dly,
    output logic                     LVBL_dly
);

    localparam int LW    = (LAYERS <= 2) ? 1 : 2;
    localparam int DEPTH = 1 << AW;

    logic [LW-1:0]   win_idx, win_idx_r;
    logic [PXLW-1:0] win_pxl, win_pxl_r;
    logic [PALW-1:0] pal_sel_r;
    logic [2:0]      hb_dl, vb_dl;
    logic [COLW-1:0] col_r, col_g, col_b;
    logic [AW-1:0]   rd_addr;

    logic [COLW-1:0] prom_r [0:DEPTH-1];
    logic [COLW-1:0] prom_g [0:DEPTH-1];
    logic [COLW-1:0] prom_b [0:DEPTH-1];

    generate
        if (LAYERS == 1) begin : g_single
            assign win_idx = '0;
            assign win_pxl = layer_en[0] ? layer_pxl[PXLW-1:0] : '0;
        end else begin : g_prio
            logic found;
            // Ascending scan: with prio_swap the first opaque hit sticks,
            // otherwise later (higher-index) hits overwrite earlier ones.
            always_comb begin
                win_idx = '0;
                win_pxl = layer_en[0] ? layer_pxl[PXLW-1:0] : '0;
                found   = 1'b0;
                for (int n = 0; n < LAYERS; n++) begin
                    if (layer_en[n] && layer_pxl[n*PXLW +: PXLW] != '0 &&
                        !(prio_swap && found)) begin
                        win_idx = LW'(n);
                        win_pxl = layer_pxl[n*PXLW +: PXLW];
                        found   = 1'b1;
                    end
                end
            end
        end
    endgenerate

    assign rd_addr  = {pal_sel_r, win_idx_r, win_pxl_r};
    assign LHBL_dly = hb_dl[2];
    assign LVBL_dly = vb_dl[2];

    // PROMs are not reset; a write and a read on the same edge return old data.
    always_ff @(posedge clk) begin
        if (prog_en[0]) prom_r[prog_addr] <= prog_data;
        if (prog_en[1]) prom_g[prog_addr] <= prog_data;
        if (prog_en[2]) prom_b[prog_addr] <= prog_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_idx_r <= '0;
            win_pxl_r <= '0;
            pal_sel_r <= '0;
            hb_dl     <= '0;
            vb_dl     <= '0;
            col_r     <= '0;
            col_g     <= '0;
            col_b     <= '0;
            red       <= '0;
            green     <= '0;
            blue      <= '0;
        end else if (pxl_cen) begin
            win_idx_r <= win_idx;
            win_pxl_r <= win_pxl;
            pal_sel_r <= pal_sel;
            hb_dl     <= {hb_dl[1:0], LHBL};
            vb_dl     <= {vb_dl[1:0], LVBL};
            col_r     <= prom_r[rd_addr];
            col_g     <= prom_g[rd_addr];
            col_b     <= prom_b[rd_addr];
            // Blank gate uses the entry that moves into the last slot this tick
            if (hb_dl[1] && vb_dl[1]) begin
                red   <= col_r;
                green <= col_g;
                blue  <= col_b;
            end else begin
                red   <= '0;
                green <= '0;
                blue  <= '0;
            end
        end
    end

endmodule

// File: tb/tb_jtkicker_colmix_n.sv
// Scoreboard bench for the colour mixer: a 2-layer instance checked every pixel
// tick against a shadow PROM model, plus a 4-layer instance for priority.
module tb_jtkicker_colmix_n;

    typedef struct {
        logic [7:0] addr;
        logic       hb, vb;
        logic [3:0] r, g, b;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n, pxl_cen, LHBL, LVBL;
    logic [2:0]  pal_sel;
    logic        prio_swap;
    logic [1:0]  layer_en;
    logic [7:0]  layer_pxl;
    logic [7:0]  prog_addr;
    logic [3:0]  prog_data;
    logic [2:0]  prog_en;
    logic [3:0]  red, green, blue;
    logic        LHBL_dly, LVBL_dly;

    logic [2:0]  pal_sel4;
    logic        prio_swap4;
    logic [3:0]  layer_en4;
    logic [15:0] layer_pxl4;
    logic [8:0]  prog_addr4;
    logic [3:0]  prog_data4;
    logic [2:0]  prog_en4;
    logic [3:0]  red4, green4, blue4;
    logic        LHBL_dly4, LVBL_dly4;

    logic [3:0]  sh_r [0:255];
    logic [3:0]  sh_g [0:255];
    logic [3:0]  sh_b [0:255];
    exp_t        sb[$];
    exp_t        last_e;
    int          n_tests = 0;
    int          n_fail  = 0;

    always #5 clk = ~clk;

    jtkicker_colmix_n #(.LAYERS(2)) dut (
        .clk(clk), .rst_n(rst_n), .pxl_cen(pxl_cen), .pal_sel(pal_sel),
        .prio_swap(prio_swap), .layer_en(layer_en), .layer_pxl(layer_pxl),
        .LHBL(LHBL), .LVBL(LVBL), .prog_addr(prog_addr), .prog_data(prog_data),
        .prog_en(prog_en), .red(red), .green(green), .blue(blue),
        .LHBL_dly(LHBL_dly), .LVBL_dly(LVBL_dly)
    );

    jtkicker_colmix_n #(.LAYERS(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .pxl_cen(pxl_cen), .pal_sel(pal_sel4),
        .prio_swap(prio_swap4), .layer_en(layer_en4), .layer_pxl(layer_pxl4),
        .LHBL(LHBL), .LVBL(LVBL), .prog_addr(prog_addr4), .prog_data(prog_data4),
        .prog_en(prog_en4), .red(red4), .green(green4), .blue(blue4),
        .LHBL_dly(LHBL_dly4), .LVBL_dly(LVBL_dly4)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int model_addr(input int nl, input int lw, input int pal, input bit swap,
                                      input logic [3:0] en, input logic [15:0] pix);
        int idx;
        int p;
        idx = 0;
        p   = en[0] ? int'(pix[3:0]) : 0;
        if (!swap) begin
            for (int n = nl - 1; n >= 0; n--)
                if (en[n] && pix[n*4 +: 4] != 4'h0) begin idx = n; p = int'(pix[n*4 +: 4]); break; end
        end else begin
            for (int n = 0; n < nl; n++)
                if (en[n] && pix[n*4 +: 4] != 4'h0) begin idx = n; p = int'(pix[n*4 +: 4]); break; end
        end
        return (pal << (lw + 4)) | (idx << 4) | p;
    endfunction

    function automatic logic [3:0] pat_r(input logic [7:0] a);
        return a[3:0] ^ a[7:4] ^ 4'h9;
    endfunction
    function automatic logic [3:0] pat_g(input logic [7:0] a);
        return a[3:0] + 4'(a[7:4] * 3);
    endfunction
    function automatic logic [3:0] pat4_r(input logic [8:0] a);
        return a[3:0] ^ a[7:4] ^ {a[8], 3'b000};
    endfunction

    function automatic exp_t zero_e();
        exp_t z;
        z.addr = '0; z.hb = 1'b0; z.vb = 1'b0; z.r = '0; z.g = '0; z.b = '0;
        return z;
    endfunction

    task automatic compare_out(input exp_t e, input string tag);
        logic vis;
        vis = e.hb & e.vb;
        check_eq({tag, ".red"},   red,   vis ? e.r : 4'h0);
        check_eq({tag, ".green"}, green, vis ? e.g : 4'h0);
        check_eq({tag, ".blue"},  blue,  vis ? e.b : 4'h0);
        check_eq({tag, ".hbl"},   LHBL_dly, e.hb);
        check_eq({tag, ".vbl"},   LVBL_dly, e.vb);
    endtask

    // One pixel tick: the entry pushed last tick is read from the PROMs on this
    // edge, so its colour is resolved from the shadow before any write lands.
    task automatic tick(input string tag, input logic [2:0] pen = 3'b000,
                        input logic [7:0] paddr = 8'h00, input logic [3:0] pdata = 4'h0);
        exp_t e;
        exp_t t;
        if (sb.size() > 0) begin
            t   = sb[sb.size()-1];
            t.r = sh_r[t.addr]; t.g = sh_g[t.addr]; t.b = sh_b[t.addr];
            sb[sb.size()-1] = t;
        end
        e.addr = 8'(model_addr(2, 1, int'(pal_sel), prio_swap, {2'b00, layer_en}, {8'h00, layer_pxl}));
        e.hb = LHBL; e.vb = LVBL; e.r = '0; e.g = '0; e.b = '0;
        sb.push_back(e);
        prog_addr = paddr; prog_data = pdata; prog_en = pen;
        if (pen[0]) sh_r[paddr] = pdata;
        if (pen[1]) sh_g[paddr] = pdata;
        if (pen[2]) sh_b[paddr] = pdata;
        pxl_cen = 1'b1;
        @(posedge clk); #1;
        pxl_cen = 1'b0; prog_en = 3'b000;
        e = sb.pop_front();
        last_e = e;
        compare_out(e, tag);
    endtask

    task automatic ticks(input string tag, input int n);
        for (int i = 0; i < n; i++) tick(tag);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; pxl_cen = 1'b0; LHBL = 1'b1; LVBL = 1'b1;
        pal_sel = '0; prio_swap = 1'b0; layer_en = 2'b11; layer_pxl = '0;
        prog_addr = '0; prog_data = '0; prog_en = '0;
        pal_sel4 = '0; prio_swap4 = 1'b0; layer_en4 = 4'hF; layer_pxl4 = '0;
        prog_addr4 = '0; prog_data4 = '0; prog_en4 = '0;
        last_e = zero_e();

        repeat (3) @(posedge clk);
        #1;
        compare_out(zero_e(), "reset");
        check_eq("reset.red4", red4, 4'h0);

        rst_n = 1'b1;
        sb.push_back(zero_e());
        sb.push_back(zero_e());

        // PROM load; all three strobes together on the 2-layer instance
        for (int a = 0; a < 512; a++) begin
            logic [8:0] a9;
            a9 = 9'(a);
            prog_addr4 = a9; prog_data4 = pat4_r(a9); prog_en4 = 3'b001;
            if (a < 256) begin
                prog_addr = a9[7:0]; prog_data = pat_r(a9[7:0]); prog_en = 3'b111;
                sh_r[a9[7:0]] = pat_r(a9[7:0]); sh_g[a9[7:0]] = pat_r(a9[7:0]);
                sh_b[a9[7:0]] = pat_r(a9[7:0]);
            end else prog_en = 3'b000;
            @(posedge clk); #1;
        end
        prog_en4 = 3'b000; prog_en = 3'b000;
        // Separate strobes so G and B hold different data from R
        for (int a = 0; a < 256; a++) begin
            logic [7:0] a8;
            a8 = 8'(a);
            prog_addr = a8; prog_data = pat_g(a8); prog_en = 3'b010; sh_g[a8] = pat_g(a8);
            @(posedge clk); #1;
            prog_data = ~a8[3:0]; prog_en = 3'b100; sh_b[a8] = ~a8[3:0];
            @(posedge clk); #1;
        end
        for (int a = 0; a < 512; a++) begin
            prog_addr4 = 9'(a); prog_data4 = 4'(a >> 4); prog_en4 = 3'b010;
            @(posedge clk); #1;
        end
        prog_en = 3'b000; prog_en4 = 3'b000;

        layer_pxl = {4'h5, 4'h3};
        ticks("hi_wins", 4);
        prio_swap = 1'b1;
        ticks("lo_wins", 3);
        prio_swap = 1'b0; layer_pxl = {4'h0, 4'h3};
        ticks("l1_clear", 3);
        layer_en = 2'b01; layer_pxl = {4'h5, 4'h3};
        ticks("l1_masked", 3);
        layer_en = 2'b00;
        ticks("bg", 3);
        layer_en = 2'b11; pal_sel = 3'd5; layer_pxl = {4'hA, 4'h3};
        ticks("pal5", 3);

        LHBL = 1'b0; tick("hblank");
        LHBL = 1'b1; ticks("hblank_after", 2);
        LVBL = 1'b0; tick("vblank");
        LVBL = 1'b1; ticks("vblank_after", 3);

        // Freeze with changing inputs: outputs must hold, then resume in order
        for (int i = 0; i < 4; i++) begin
            pal_sel = 3'(i); layer_pxl = {4'(i + 1), 4'(7 - i)};
            tick("pre_freeze");
        end
        for (int i = 0; i < 10; i++) begin
            layer_pxl = 8'($urandom_range(0, 255)); pal_sel = 3'($urandom_range(0, 7));
            @(posedge clk); #1;
            compare_out(last_e, "freeze");
        end
        pal_sel = 3'd3; layer_pxl = {4'h4, 4'h4};
        ticks("resume", 4);

        // Write R[0x15] on the edge that reads 0x15
        pal_sel = 3'd0; layer_pxl = {4'h5, 4'h3};
        tick("coll_a");
        tick("coll_w", 3'b001, 8'h15, 4'hC);
        ticks("coll_after", 4);

        // Asynchronous reset mid-line
        pal_sel = 3'd2; layer_pxl = {4'h6, 4'h1};
        ticks("pre_rst", 3);
        #3 rst_n = 1'b0;
        #1 compare_out(zero_e(), "async_rst");
        check_eq("async_rst.red4", red4, 4'h0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        sb.delete();
        sb.push_back(zero_e());
        sb.push_back(zero_e());
        ticks("post_rst", 4);

        // 4-layer priority
        pal_sel4 = 3'd2; layer_en4 = 4'hF; layer_pxl4 = {4'h2, 4'h0, 4'h7, 4'h0};
        prio_swap4 = 1'b0;
        ticks("l4_hi", 3);
        begin
            logic [8:0] a4;
            a4 = 9'(model_addr(4, 2, 2, 1'b0, layer_en4, layer_pxl4));
            check_eq("l4_hi.red", red4, pat4_r(a4));
            check_eq("l4_hi.green", green4, a4[7:4]);
            prio_swap4 = 1'b1;
            ticks("l4_lo", 3);
            a4 = 9'(model_addr(4, 2, 2, 1'b1, layer_en4, layer_pxl4));
            check_eq("l4_lo.red", red4, pat4_r(a4));
            check_eq("l4_lo.green", green4, a4[7:4]);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
